// File: rtl/solo_squash_inputs.sv
// Button conditioning for the solo_squash core: 2-flop sync, ticked debounce, press strobes.
// Optional macro PAUSE_TOGGLE_EN turns pause_n into a press-to-toggle latch (new game unpauses).
module solo_squash_inputs #(
    parameter int DEB_TICK_DIV = 25000,
    parameter int DEB_COUNT    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_up_n,
    input  logic       raw_down_n,
    input  logic       raw_new_game_n,
    input  logic       raw_pause_n,
    output logic       up_key_n,
    output logic       down_key_n,
    output logic       new_game_n,
    output logic       pause_n,
    output logic [3:0] press_pulse,
    output logic       tick
);

    localparam int PRE_W = (DEB_TICK_DIV > 2) ? $clog2(DEB_TICK_DIV) : 1;
    localparam int CNT_W = (DEB_COUNT > 2) ? $clog2(DEB_COUNT) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DEB_TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_COUNT - 1);

    // Channel order everywhere: [0]=up, [1]=down, [2]=new_game, [3]=pause.
    logic [3:0]       raw_n;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] deb_cnt [4];
    logic [3:0]       stable;
    logic [3:0]       accept;
    logic [3:0]       fall;

    assign raw_n = {raw_pause_n, raw_new_game_n, raw_down_n, raw_up_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'hf;
            sync2 <= 4'hf;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PRE_W'(1);
            tick    <= (pre_cnt == PRE_MAX);
        end
    end

    // A channel flips on the tick where its counter already holds DEB_COUNT-1 differing ticks.
    always_comb begin
        accept = '0;
        fall   = '0;
        for (int i = 0; i < 4; i++) begin
            accept[i] = tick && (sync2[i] != stable[i]) && (deb_cnt[i] == CNT_MAX);
            fall[i]   = accept[i] && !sync2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable      <= 4'hf;
            press_pulse <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            press_pulse <= fall;
            for (int i = 0; i < 4; i++) begin
                if (tick) begin
                    if (sync2[i] == stable[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (accept[i]) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign up_key_n   = stable[0];
    assign down_key_n = stable[1];
    assign new_game_n = stable[2];

`ifdef PAUSE_TOGGLE_EN
    // Updated from the same-cycle fall terms so the change lines up with press_pulse.
    logic pause_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pause_q <= 1'b1;
        end else if (fall[2]) begin
            pause_q <= 1'b1;
        end else if (fall[3]) begin
            pause_q <= ~pause_q;
        end
    end

    assign pause_n = pause_q;
`else
    assign pause_n = stable[3];
`endif

endmodule

// File: tb/tb_solo_squash_inputs.sv
// Bench for solo_squash_inputs with DEB_TICK_DIV=4, DEB_COUNT=3; compile with or without PAUSE_TOGGLE_EN.
module tb_solo_squash_inputs;

    localparam int DIV = 4;
    localparam int CNT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_up_n, raw_down_n, raw_new_game_n, raw_pause_n;
    logic       up_key_n, down_key_n, new_game_n, pause_n;
    logic [3:0] press_pulse;
    logic       tick;
    logic [3:0] keys;

    int checks = 0;
    int errors = 0;

    solo_squash_inputs #(.DEB_TICK_DIV(DIV), .DEB_COUNT(CNT)) dut (
        .clk(clk), .reset(reset),
        .raw_up_n(raw_up_n), .raw_down_n(raw_down_n),
        .raw_new_game_n(raw_new_game_n), .raw_pause_n(raw_pause_n),
        .up_key_n(up_key_n), .down_key_n(down_key_n),
        .new_game_n(new_game_n), .pause_n(pause_n),
        .press_pulse(press_pulse), .tick(tick)
    );

    always #5 clk = ~clk;

    assign keys = {pause_n, new_game_n, down_key_n, up_key_n};

    // Reference: delay raw by two edges, sample on every DIV-th cycle since reset,
    // accept a level after CNT consecutive differing samples.
    logic [3:0] m_d1 = 4'hf, m_d2 = 4'hf, m_stable = 4'hf, m_pulse = 4'h0;
    logic       m_tick = 1'b0, m_pause = 1'b1;
    int         m_run [4] = '{0, 0, 0, 0};
    int         m_cyc = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_d1 = 4'hf; m_d2 = 4'hf; m_stable = 4'hf; m_pulse = 4'h0;
            m_tick = 1'b0; m_pause = 1'b1; m_cyc = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            m_pulse = 4'h0;
            if (m_tick) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_d2[i] == m_stable[i]) begin
                        m_run[i] = 0;
                    end else begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == CNT) begin
                            m_stable[i] = m_d2[i];
                            m_run[i]    = 0;
                            if (!m_d2[i]) m_pulse[i] = 1'b1;
                        end
                    end
                end
            end
`ifdef PAUSE_TOGGLE_EN
            if (m_pulse[2]) m_pause = 1'b1;
            else if (m_pulse[3]) m_pause = ~m_pause;
`else
            m_pause = m_stable[3];
`endif
            m_d2 = m_d1;
            m_d1 = {raw_pause_n, raw_new_game_n, raw_down_n, raw_up_n};
            m_cyc = m_cyc + 1;
            m_tick = (m_cyc % DIV == 0);
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checks++;
            if ({keys, press_pulse, tick} !== {m_pause, m_stable[2:0], m_pulse, m_tick}) begin
                errors++;
                $display("FAIL model_compare t=%0t dut keys=%b pulse=%b tick=%b exp keys=%b pulse=%b tick=%b",
                         $time, keys, press_pulse, tick, {m_pause, m_stable[2:0]}, m_pulse, m_tick);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // Waits for keys[idx] to reach lvl; lat is 1 for the first edge after the call, 0 on timeout.
    task automatic wait_out(input string name, input int idx, input logic lvl,
                            output int lat, output logic [3:0] pulses);
        lat = 0;
        pulses = 4'h0;
        for (int n = 1; n <= 30; n++) begin
            cycle();
            pulses = pulses | press_pulse;
            if (keys[idx] == lvl) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=%b expected=%b", name, keys[idx], lvl);
        end
    endtask

    int         lat;
    logic [3:0] pl;
    logic       seen_low;
    logic       seen_pulse;

    initial begin
        reset = 1'b1;
        raw_up_n = 1'b0; raw_down_n = 1'b0; raw_new_game_n = 1'b0; raw_pause_n = 1'b0;

        // Reset with every button held.
        repeat (3) begin
            cycle();
            check("reset_keys", {28'h0, keys}, 32'hf);
            check("reset_pulse", {28'h0, press_pulse}, 32'h0);
            check("reset_tick", {31'h0, tick}, 32'h0);
        end
        reset = 1'b0;
        raw_up_n = 1'b1; raw_down_n = 1'b1; raw_new_game_n = 1'b1; raw_pause_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            check($sformatf("tick_cycle_%0d", n), {31'h0, tick}, {31'h0, (n % 4 == 0)});
        end

        // Clean press and release.
        raw_up_n = 1'b0;
        wait_out("press_up", 0, 1'b0, lat, pl);
        check("press_up_latency_ok", {31'h0, (lat >= 11 && lat <= 14)}, 32'h1);
        check("press_up_pulse", {28'h0, press_pulse}, 32'h1);
        cycle();
        check("press_up_pulse_one_cycle", {28'h0, press_pulse}, 32'h0);
        idle(5);
        raw_up_n = 1'b1;
        wait_out("release_up", 0, 1'b1, lat, pl);
        check("release_up_latency_ok", {31'h0, (lat >= 1 && lat <= 14)}, 32'h1);
        check("release_up_no_pulse", {28'h0, pl}, 32'h0);
        idle(20);

        // Bounce train aligned so the short high gap contains a sample tick.
        for (int n = 0; n < 8 && !tick; n++) cycle();
        check("bounce_tick_aligned", {31'h0, tick}, 32'h1);
        seen_low = 1'b0;
        seen_pulse = 1'b0;
        raw_down_n = 1'b0;
        for (int n = 0; n < 46; n++) begin
            if (n == 8) raw_down_n = 1'b1;
            if (n == 11) raw_down_n = 1'b0;
            if (n == 16) raw_down_n = 1'b1;
            cycle();
            seen_low = seen_low | !down_key_n;
            seen_pulse = seen_pulse | press_pulse[1];
        end
        check("bounce_level_held", {31'h0, seen_low}, 32'h0);
        check("bounce_no_pulse", {31'h0, seen_pulse}, 32'h0);

        // Simultaneous press of up and down.
        raw_up_n = 1'b0;
        raw_down_n = 1'b0;
        wait_out("dual_press", 0, 1'b0, lat, pl);
        check("dual_down_same_cycle", {31'h0, down_key_n}, 32'h0);
        check("dual_pulse", {28'h0, press_pulse}, 32'h3);
        raw_up_n = 1'b1;
        raw_down_n = 1'b1;
        idle(20);

        // Reset nine cycles into a press, button held throughout.
        raw_up_n = 1'b0;
        idle(9);
        check("mid_press_level", {31'h0, up_key_n}, 32'h1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("after_reset_level", {28'h0, keys}, 32'hf);
        seen_low = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cycle();
            seen_low = seen_low | !up_key_n;
        end
        check("restart_no_early_accept", {31'h0, seen_low}, 32'h0);
        wait_out("restart_accept", 0, 1'b0, lat, pl);
        check("restart_latency_ok", {31'h0, (lat >= 1 && lat <= 4)}, 32'h1);
        check("restart_pulse", {28'h0, pl}, 32'h1);
        raw_up_n = 1'b1;
        idle(20);

`ifdef PAUSE_TOGGLE_EN
        raw_pause_n = 1'b0;
        wait_out("pause_on", 3, 1'b0, lat, pl);
        check("pause_on_pulse", {28'h0, press_pulse}, 32'h8);
        raw_pause_n = 1'b1;
        idle(20);
        check("pause_latched_after_release", {31'h0, pause_n}, 32'h0);
        raw_pause_n = 1'b0;
        wait_out("pause_off", 3, 1'b1, lat, pl);
        check("pause_off_pulse", {28'h0, press_pulse}, 32'h8);
        raw_pause_n = 1'b1;
        idle(20);
        check("pause_running_after_release", {31'h0, pause_n}, 32'h1);

        raw_pause_n = 1'b0;
        wait_out("pause_again", 3, 1'b0, lat, pl);
        raw_pause_n = 1'b1;
        idle(20);
        raw_new_game_n = 1'b0;
        wait_out("new_game_press", 2, 1'b0, lat, pl);
        check("new_game_pulse", {28'h0, press_pulse}, 32'h4);
        check("new_game_unpauses", {31'h0, pause_n}, 32'h1);
        raw_new_game_n = 1'b1;
        idle(20);

        raw_pause_n = 1'b0;
        raw_new_game_n = 1'b0;
        wait_out("both_press", 2, 1'b0, lat, pl);
        check("both_pulse", {28'h0, press_pulse}, 32'hc);
        check("both_force_wins", {31'h0, pause_n}, 32'h1);
        raw_pause_n = 1'b1;
        raw_new_game_n = 1'b1;
        idle(20);
`else
        raw_pause_n = 1'b0;
        wait_out("pause_hold", 3, 1'b0, lat, pl);
        check("pause_hold_latency_ok", {31'h0, (lat >= 11 && lat <= 14)}, 32'h1);
        check("pause_hold_pulse", {28'h0, press_pulse}, 32'h8);
        seen_low = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cycle();
            seen_low = seen_low & !pause_n;
        end
        check("pause_stays_while_held", {31'h0, seen_low}, 32'h1);
        raw_pause_n = 1'b1;
        wait_out("pause_release", 3, 1'b1, lat, pl);
        check("pause_release_latency_ok", {31'h0, (lat >= 11 && lat <= 14)}, 32'h1);
        check("pause_release_no_pulse", {28'h0, pl}, 32'h0);
        idle(10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
